// File: rtl/hysteresis_counter_table.sv
// Table of saturating hysteresis counters with a one-entry-per-cycle clear sweep.
// Optional HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN forwards a same-cycle update to the read port.
module hysteresis_counter_table #(
    parameter int DEPTH       = 16,
    parameter int DEPTH_LOG2  = $clog2(DEPTH),
    parameter int RANGE       = 4,
    parameter int RANGE_LOG2  = $clog2(RANGE),
    parameter int RESET_VALUE = 0,
    parameter int COERCIVITY  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  read_enable,
    input  logic [DEPTH_LOG2-1:0] read_index,
    output logic [RANGE_LOG2-1:0] read_count,
    output logic                  read_prediction,
    input  logic                  update_enable,
    input  logic [DEPTH_LOG2-1:0] update_index,
    input  logic                  update_increment,
    input  logic                  update_decrement
);

    // state    | meaning
    // IDLE     | normal operation, updates accepted
    // CLEARING | sweeping RESET_VALUE into entries 0..DEPTH-1, updates dropped
    typedef enum logic {ST_IDLE, ST_CLEARING} state_t;

    localparam logic [RANGE_LOG2-1:0] HALF_LOW  = RANGE_LOG2'(RANGE / 2 - 1);
    localparam logic [RANGE_LOG2-1:0] HALF_HIGH = RANGE_LOG2'(RANGE / 2);
    localparam logic [RANGE_LOG2-1:0] JUMP_HIGH = RANGE_LOG2'(RANGE / 2 + COERCIVITY);
    localparam logic [RANGE_LOG2-1:0] JUMP_LOW  = RANGE_LOG2'(RANGE / 2 - 1 - COERCIVITY);
    localparam logic [RANGE_LOG2-1:0] MAX_COUNT = RANGE_LOG2'(RANGE - 1);
    localparam logic [RANGE_LOG2-1:0] MIN_COUNT = RANGE_LOG2'(0);
    localparam logic [RANGE_LOG2-1:0] ONE_COUNT = RANGE_LOG2'(1);
    localparam logic [RANGE_LOG2-1:0] RST_COUNT = RANGE_LOG2'(RESET_VALUE);
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX  = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0] ONE_IDX   = DEPTH_LOG2'(1);

    state_t                  state;
    state_t                  next_state;
    logic [DEPTH_LOG2-1:0]   sweep_index;
    logic [RANGE_LOG2-1:0]   counts [DEPTH];
    logic                    update_accept;
    logic [RANGE_LOG2-1:0]   current;
    logic [RANGE_LOG2-1:0]   updated;
    logic [RANGE_LOG2-1:0]   read_value;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (clear) next_state = ST_CLEARING;
            ST_CLEARING: if (sweep_index == LAST_IDX) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // The cycle that samples clear in IDLE also drops its update.
    assign update_accept = update_enable && (state == ST_IDLE) && !clear;
    assign current       = counts[update_index];

    always_comb begin
        updated = current;
        if (update_increment && !update_decrement) begin
            if (current == HALF_LOW)
                updated = JUMP_HIGH;
            else if (current != MAX_COUNT)
                updated = current + ONE_COUNT;
        end else if (update_decrement && !update_increment) begin
            if (current == HALF_HIGH)
                updated = JUMP_LOW;
            else if (current != MIN_COUNT)
                updated = current - ONE_COUNT;
        end
    end

    always_comb begin
        read_value = counts[read_index];
`ifdef HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN
        if (update_accept && (read_index == update_index))
            read_value = updated;
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            sweep_index     <= '0;
            read_count      <= '0;
            read_prediction <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                counts[i] <= RST_COUNT;
        end else begin
            state <= next_state;
            busy  <= (next_state == ST_CLEARING);
            if (state == ST_CLEARING)
                sweep_index <= (sweep_index == LAST_IDX) ? '0 : sweep_index + ONE_IDX;
            if (read_enable) begin
                read_count      <= read_value;
                read_prediction <= (read_value >= HALF_HIGH);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((state == ST_CLEARING) && (sweep_index == DEPTH_LOG2'(i)))
                    counts[i] <= RST_COUNT;
                else if (update_accept && (update_index == DEPTH_LOG2'(i)))
                    counts[i] <= updated;
            end
        end
    end

endmodule

// File: tb/tb_hysteresis_counter_table.sv
// Directed bench for hysteresis_counter_table (DEPTH=16, RANGE=8, COERCIVITY=1).
// Read expectations are queued at drive time and popped when the registered read lands.
module tb_hysteresis_counter_table;

    localparam int DEPTH       = 16;
    localparam int RANGE       = 8;
    localparam int RESET_VALUE = 0;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       clear = 1'b0;
    logic       busy;
    logic       read_enable = 1'b0;
    logic [3:0] read_index = '0;
    logic [2:0] read_count;
    logic       read_prediction;
    logic       update_enable = 1'b0;
    logic [3:0] update_index = '0;
    logic       update_increment = 1'b0;
    logic       update_decrement = 1'b0;

    int checks = 0;
    int errors = 0;
    int model [DEPTH];
    int exp_q [$];
    int last_count = 0;

`ifdef HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN
    localparam int BYPASS_READ = 2;
`else
    localparam int BYPASS_READ = 1;
`endif

    hysteresis_counter_table #(
        .DEPTH(DEPTH), .RANGE(RANGE), .RESET_VALUE(RESET_VALUE), .COERCIVITY(1)
    ) dut (
        .clock(clock), .resetn(resetn), .clear(clear), .busy(busy),
        .read_enable(read_enable), .read_index(read_index),
        .read_count(read_count), .read_prediction(read_prediction),
        .update_enable(update_enable), .update_index(update_index),
        .update_increment(update_increment), .update_decrement(update_decrement)
    );

    always #5 clock = ~clock;

    // Hysteresis rule for RANGE=8, COERCIVITY=1: 3 jumps up to 5, 4 jumps down to 2.
    function automatic int next_val(int v, bit inc, bit dec);
        if (inc && !dec) begin
            if (v == 3) return 5;
            if (v == 7) return 7;
            return v + 1;
        end
        if (dec && !inc) begin
            if (v == 4) return 2;
            if (v == 0) return 0;
            return v - 1;
        end
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(bit re, int ri, int rexp, bit ue, int ui, bit inc, bit dec, bit acc);
        int e;
        read_enable      = re;
        read_index       = ri[3:0];
        update_enable    = ue;
        update_index     = ui[3:0];
        update_increment = inc;
        update_decrement = dec;
        if (re) exp_q.push_back(rexp);
        if (ue && acc) model[ui] = next_val(model[ui], inc, dec);
        @(posedge clock);
        #1;
        if (re) begin
            e = exp_q.pop_front();
            check("read_count", read_count, e);
            check("read_prediction", read_prediction, (e >= RANGE / 2) ? 1 : 0);
            last_count = e;
        end else begin
            check("read_hold", read_count, last_count);
        end
        read_enable      = 1'b0;
        update_enable    = 1'b0;
        update_increment = 1'b0;
        update_decrement = 1'b0;
    endtask

    task automatic rd(int idx, int exp);
        step(1'b1, idx, exp, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic upd(int idx, bit inc, bit dec);
        step(1'b0, 0, 0, 1'b1, idx, inc, dec, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = RESET_VALUE;
        #2;
        check("reset_busy", busy, 0);
        check("reset_read_count", read_count, 0);
        check("reset_read_prediction", read_prediction, 0);
        #10 resetn = 1'b1;

        for (int i = 0; i < DEPTH; i++) rd(i, RESET_VALUE);

        // entry 5: 0 -> 3, then jump to 5 on increment
        repeat (3) upd(5, 1'b1, 1'b0);
        rd(5, 3);
        upd(5, 1'b1, 1'b0);
        rd(5, 5);
        rd(4, 0);
        rd(6, 0);
        upd(5, 1'b0, 1'b1);
        rd(5, 4);
        upd(5, 1'b0, 1'b1);
        rd(5, 2);

        // entry 2: reach 4, jump down to 2, saturate at 0 and 7
        repeat (4) upd(2, 1'b1, 1'b0);
        upd(2, 1'b0, 1'b1);
        rd(2, 4);
        upd(2, 1'b0, 1'b1);
        rd(2, 2);
        repeat (2) upd(2, 1'b0, 1'b1);
        rd(2, 0);
        upd(2, 1'b0, 1'b1);
        rd(2, 0);
        repeat (6) upd(2, 1'b1, 1'b0);
        rd(2, 7);
        upd(2, 1'b1, 1'b0);
        rd(2, 7);
        upd(2, 1'b0, 1'b1);
        rd(2, 6);
        upd(2, 1'b1, 1'b1);
        rd(2, 6);
        upd(2, 1'b0, 1'b0);
        rd(2, 6);

        // same-cycle read and update on entry 9
        upd(9, 1'b1, 1'b0);
        rd(9, 1);
        step(1'b1, 9, BYPASS_READ, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        rd(9, 2);
        step(1'b1, 5, 2, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        rd(9, 3);

        // full clear sweep with updates offered throughout
        for (int i = 0; i < DEPTH; i++) upd(i, 1'b1, 1'b0);
        clear = 1'b1;
        step(1'b0, 0, 0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = RESET_VALUE;
        for (int i = 0; i < DEPTH; i++) begin
            check("sweep_busy", busy, 1);
            clear = (i == 4);
            if (i == DEPTH - 1)
                step(1'b1, 15, 1, 1'b1, 15, 1'b1, 1'b0, 1'b0);
            else
                step(1'b0, 0, 0, 1'b1, (i + 8) % DEPTH, 1'b1, 1'b0, 1'b0);
            clear = 1'b0;
        end
        check("sweep_done_busy", busy, 0);
        idle();
        check("after_sweep_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) rd(i, RESET_VALUE);

        // reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) upd(i, 1'b1, 1'b0);
        rd(12, 1);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("pre_reset_busy", busy, 1);
            idle();
        end
        resetn = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_read_count", read_count, 0);
        last_count = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = RESET_VALUE;
        #3 resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            idle();
            check("post_reset_busy", busy, 0);
        end
        upd(4, 1'b1, 1'b0);
        rd(4, 1);
        for (int i = 0; i < DEPTH; i++) rd(i, model[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
